// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl: read side of the camera-to-VGA async pixel FIFO.
// Pixel-clock domain; RAM fetch, 2-entry output buffer, Gray rptr.
module fifo_rd_ctrl #(
  parameter int ADDR_W   = 9,
  parameter int DATA_W   = 12,
  parameter int AE_LEVEL = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W:0]   wptr_gray_sync,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W:0]   rptr_gray,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              empty,
  output logic              almost_empty,
  output logic [ADDR_W:0]   level
);

  localparam logic [ADDR_W:0] ONE =
    {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0] AE =
    AE_LEVEL[ADDR_W:0];

  logic [ADDR_W:0]   rbin;
  logic [ADDR_W:0]   rbin_nxt;
  logic [ADDR_W:0]   wbin;
  logic              pend;
  logic              head_v;
  logic              skid_v;
  logic [DATA_W-1:0] head_d;
  logic [DATA_W-1:0] skid_d;
  logic              pop;
  logic [1:0]        occ;
  logic [1:0]        lim;

  // Gray to binary: each bit is the XOR of all bits at or above it
  always_comb begin
    wbin = '0;
    for (int i = 0; i <= ADDR_W; i++) begin
      wbin[i] = ^(wptr_gray_sync >> i);
    end
  end

  // Occupancy status and read issue decision
  always_comb begin
    rbin_nxt     = rbin + ONE;
    level        = wbin - rbin;
    empty        = (wbin == rbin);
    almost_empty = (level <= AE);
    pop          = head_v & m_ready;
    occ          = {1'b0, head_v}
                 + {1'b0, skid_v}
                 + {1'b0, pend};
    lim          = {1'b0, pop} + 2'd1;
    rd_en        = rst_n & ~empty & (occ <= lim);
  end

  assign rd_addr = rbin[ADDR_W-1:0];
  assign m_valid = head_v;
  assign m_data  = head_d;

  // Read pointer, its Gray copy and the in-flight flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rbin      <= '0;
      rptr_gray <= '0;
      pend      <= 1'b0;
    end else begin
      pend <= rd_en;
      if (rd_en) begin
        rbin      <= rbin_nxt;
        rptr_gray <= rbin_nxt ^ (rbin_nxt >> 1);
      end
    end
  end

  // Head/skid buffer: pop shifts skid forward, returns fill in order
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_v <= 1'b0;
      skid_v <= 1'b0;
      head_d <= '0;
      skid_d <= '0;
    end else if (pop) begin
      if (skid_v) begin
        head_d <= skid_d;
        skid_v <= pend;
        if (pend) skid_d <= rd_data;
      end else begin
        head_v <= pend;
        if (pend) head_d <= rd_data;
      end
    end else if (pend) begin
      if (!head_v) begin
        head_v <= 1'b1;
        head_d <= rd_data;
      end else begin
        skid_v <= 1'b1;
        skid_d <= rd_data;
      end
    end
  end

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// tb_fifo_rd_ctrl: randomized and directed bench for fifo_rd_ctrl.
// Reference: pointer arithmetic over issue/arrive/pop positions.
module tb_fifo_rd_ctrl;

  localparam int AW = 9;
  localparam int DW = 12;
  localparam int D  = 512;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW:0]   wptr_gray_sync = '0;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data = '0;
  logic [AW:0]   rptr_gray;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_data;
  logic          empty;
  logic          almost_empty;
  logic [AW:0]   level;

  logic [DW-1:0] mem [D];

  // model: wb write ptr, rp issue ptr, ap arrived ptr, hp pop ptr
  logic [AW:0] wb = '0;
  logic [AW:0] rp = '0;
  logic [AW:0] ap = '0;
  logic [AW:0] hp = '0;

  int checks = 0;
  int errors = 0;

  fifo_rd_ctrl #(.ADDR_W(AW), .DATA_W(DW), .AE_LEVEL(16)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .wptr_gray_sync(wptr_gray_sync),
    .rd_en(rd_en),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .rptr_gray(rptr_gray),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_data(m_data),
    .empty(empty),
    .almost_empty(almost_empty),
    .level(level)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  function automatic logic [AW:0] gray(input logic [AW:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic ev();
    return ap != hp;
  endfunction

  function automatic logic erd();
    logic [AW:0] o;
    int p;
    o = rp - hp;
    p = (ev() && m_ready) ? 1 : 0;
    return rst_n && (wb != rp) && (int'(o) - p <= 1);
  endfunction

  task automatic set_w(input logic [AW:0] b);
    wb = b;
    wptr_gray_sync = gray(b);
  endtask

  task automatic tick();
    logic p;
    logic r;
    p = ev() && m_ready;
    r = erd();
    @(posedge clk);
    if (!rst_n) begin
      rp = '0; ap = '0; hp = '0;
    end else begin
      ap = rp;
      if (r) rp = rp + 1'b1;
      if (p) hp = hp + 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    m_ready = 1'b0;
    set_w('0);
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    m_ready = 1'b0;
    set_w('0);
    repeat (3) tick();
    #1;
    checks += 7;
    if (m_valid !== 1'b0) begin errors++;
      $display("FAIL rst_valid got %b exp 0", m_valid); end
    if (m_data !== '0) begin errors++;
      $display("FAIL rst_data got %h exp 000", m_data); end
    if (rd_en !== 1'b0) begin errors++;
      $display("FAIL rst_rden got %b exp 0", rd_en); end
    if (rptr_gray !== '0) begin errors++;
      $display("FAIL rst_rgray got %h exp 0", rptr_gray); end
    if (empty !== 1'b1) begin errors++;
      $display("FAIL rst_empty got %b exp 1", empty); end
    if (almost_empty !== 1'b1) begin errors++;
      $display("FAIL rst_ae got %b exp 1", almost_empty); end
    if (level !== '0) begin errors++;
      $display("FAIL rst_level got %0d exp 0", level); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    do_reset();
    mem[0] = 12'hABC;
    set_w(10'd1);
    #1;
    checks += 2;
    if (rd_en !== 1'b1) begin errors++;
      $display("FAIL single_rden got %b exp 1", rd_en); end
    if (rd_addr !== 9'd0) begin errors++;
      $display("FAIL single_addr got %0d exp 0", rd_addr); end
    tick();
    #1;
    checks += 3;
    if (rd_en !== 1'b0) begin errors++;
      $display("FAIL single_rden2 got %b exp 0", rd_en); end
    if (m_valid !== 1'b0) begin errors++;
      $display("FAIL single_early got %b exp 0", m_valid); end
    if (rptr_gray !== 10'd1) begin errors++;
      $display("FAIL single_rgray got %h exp 1", rptr_gray); end
    for (int i = 0; i < 4; i++) begin
      tick();
      #1;
      checks += 3;
      if (m_valid !== 1'b1) begin errors++;
        $display("FAIL single_valid c%0d got %b exp 1", i, m_valid); end
      if (m_data !== 12'hABC) begin errors++;
        $display("FAIL single_data c%0d got %h exp abc", i, m_data); end
      if (empty !== 1'b1) begin errors++;
        $display("FAIL single_empty c%0d got %b exp 1", i, empty); end
    end
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    #1;
    checks++;
    if (m_valid !== 1'b0) begin errors++;
      $display("FAIL single_pop got %b exp 0", m_valid); end
  endtask

  task automatic test_burst();
    int nrd;
    int first;
    int last;
    int got [$];
    do_reset();
    for (int n = 0; n < D; n++) mem[n] = DW'(n);
    m_ready = 1'b1;
    set_w(10'd8);
    #1;
    checks++;
    if (level !== 10'd8) begin errors++;
      $display("FAIL burst_lvl0 got %0d exp 8", level); end
    nrd = 0; first = -1; last = -1;
    for (int c = 0; c < 14; c++) begin
      #1;
      checks += 2;
      if (rd_en !== erd()) begin errors++;
        $display("FAIL burst_rden c%0d got %b exp %b", c, rd_en, erd()); end
      if (level !== wb - rp) begin errors++;
        $display("FAIL burst_lvl c%0d got %0d exp %0d", c, level, wb - rp); end
      if (rd_en) nrd++;
      if (m_valid && m_ready) begin
        got.push_back(int'(m_data));
        if (first < 0) first = c;
        last = c;
      end
      tick();
    end
    checks += 3;
    if (nrd != 8) begin errors++;
      $display("FAIL burst_nrd got %0d exp 8", nrd); end
    if (last - first != 7) begin errors++;
      $display("FAIL burst_span got %0d exp 7", last - first); end
    if (got.size() != 8) begin errors++;
      $display("FAIL burst_cnt got %0d exp 8", got.size()); end
    for (int i = 0; i < got.size(); i++) begin
      checks++;
      if (got[i] != i) begin errors++;
        $display("FAIL burst_seq i%0d got %0d exp %0d", i, got[i], i); end
    end
    checks++;
    if (level !== '0) begin errors++;
      $display("FAIL burst_lvlend got %0d exp 0", level); end
  endtask

  task automatic test_toggle();
    int got [$];
    logic [AW:0] o;
    do_reset();
    set_w(10'd8);
    for (int c = 0; c < 24; c++) begin
      m_ready = (c % 2) == 0;
      #1;
      o = rp - hp;
      checks += 2;
      if (rd_en !== erd()) begin errors++;
        $display("FAIL tog_rden c%0d got %b exp %b", c, rd_en, erd()); end
      if (o > 2) begin errors++;
        $display("FAIL tog_occ c%0d got %0d exp <=2", c, o); end
      if (m_valid && m_ready) got.push_back(int'(m_data));
      tick();
    end
    m_ready = 1'b0;
    checks++;
    if (got.size() != 8) begin errors++;
      $display("FAIL tog_cnt got %0d exp 8", got.size()); end
    for (int i = 0; i < got.size(); i++) begin
      checks++;
      if (got[i] != i) begin errors++;
        $display("FAIL tog_seq i%0d got %0d exp %0d", i, got[i], i); end
    end
  endtask

  task automatic test_random();
    logic [AW:0] nw;
    logic [AW:0] lv;
    do_reset();
    for (int n = 0; n < D; n++) mem[n] = DW'($urandom);
    for (int c = 0; c < 700; c++) begin
      m_ready = ($urandom % 4) != 0;
      nw = wb + AW'($urandom_range(0, 2));
      lv = nw - rp;
      if (lv <= 10'd512) set_w(nw);
      #1;
      lv = wb - rp;
      checks += 6;
      if (rd_en !== erd()) begin errors++;
        $display("FAIL rnd_rden c%0d got %b exp %b", c, rd_en, erd()); end
      if (m_valid !== ev()) begin errors++;
        $display("FAIL rnd_valid c%0d got %b exp %b", c, m_valid, ev()); end
      if (level !== lv) begin errors++;
        $display("FAIL rnd_lvl c%0d got %0d exp %0d", c, level, lv); end
      if (empty !== (lv == 0)) begin errors++;
        $display("FAIL rnd_empty c%0d got %b", c, empty); end
      if (almost_empty !== (lv <= 16)) begin errors++;
        $display("FAIL rnd_ae c%0d got %b lvl %0d", c, almost_empty, lv); end
      if (rptr_gray !== gray(rp)) begin errors++;
        $display("FAIL rnd_rgray c%0d got %h exp %h", c, rptr_gray, gray(rp)); end
      if (rd_en) begin
        checks++;
        if (rd_addr !== rp[AW-1:0]) begin errors++;
          $display("FAIL rnd_addr c%0d got %0d exp %0d", c, rd_addr, rp[AW-1:0]); end
      end
      if (ev()) begin
        checks++;
        if (m_data !== mem[hp[AW-1:0]]) begin errors++;
          $display("FAIL rnd_data c%0d got %h exp %h", c, m_data, mem[hp[AW-1:0]]); end
      end
      tick();
    end
    m_ready = 1'b0;
  endtask

  task automatic test_wrap();
    int k;
    int n;
    int ea;
    logic [AW:0] lv;
    do_reset();
    for (int i = 0; i < D; i++) mem[i] = DW'(i * 7 + 3);
    m_ready = 1'b1;
    set_w(10'd1020);
    n = 0;
    while (hp != 10'd1020 && n < 1200) begin
      tick();
      n++;
    end
    tick();
    #1;
    checks += 2;
    if (hp != 10'd1020) begin errors++;
      $display("FAIL wrap_prefill got %0d exp 1020", hp); end
    if (rptr_gray !== gray(10'd1020)) begin errors++;
      $display("FAIL wrap_g0 got %h exp %h", rptr_gray, gray(10'd1020)); end
    set_w(10'd4);
    k = 0;
    for (int c = 0; c < 14; c++) begin
      #1;
      lv = wb - rp;
      checks += 3;
      if (level !== lv) begin errors++;
        $display("FAIL wrap_lvl c%0d got %0d exp %0d", c, level, lv); end
      if (rptr_gray !== gray(rp)) begin errors++;
        $display("FAIL wrap_rgray c%0d got %h exp %h", c, rptr_gray, gray(rp)); end
      if (rd_en !== erd()) begin errors++;
        $display("FAIL wrap_rden c%0d got %b exp %b", c, rd_en, erd()); end
      if (rd_en) begin
        ea = (1020 + k) % D;
        checks++;
        if (int'(rd_addr) != ea) begin errors++;
          $display("FAIL wrap_addr k%0d got %0d exp %0d", k, rd_addr, ea); end
        k++;
      end
      if (m_valid) begin
        checks++;
        if (m_data !== mem[hp[AW-1:0]]) begin errors++;
          $display("FAIL wrap_data c%0d got %h exp %h", c, m_data, mem[hp[AW-1:0]]); end
      end
      tick();
    end
    checks += 2;
    if (k != 8) begin errors++;
      $display("FAIL wrap_nrd got %0d exp 8", k); end
    if (rptr_gray !== 10'h006) begin errors++;
      $display("FAIL wrap_gend got %h exp 006", rptr_gray); end
    m_ready = 1'b0;
  endtask

  task automatic test_full_reset();
    do_reset();
    set_w(10'd512);
    #1;
    checks += 3;
    if (level !== 10'd512) begin errors++;
      $display("FAIL full_lvl got %0d exp 512", level); end
    if (empty !== 1'b0) begin errors++;
      $display("FAIL full_empty got %b exp 0", empty); end
    if (almost_empty !== 1'b0) begin errors++;
      $display("FAIL full_ae got %b exp 0", almost_empty); end
    for (int c = 0; c < 6; c++) begin
      #1;
      checks++;
      if (rd_en !== erd()) begin errors++;
        $display("FAIL full_rden c%0d got %b exp %b", c, rd_en, erd()); end
      tick();
    end
    checks++;
    if (m_valid !== 1'b1) begin errors++;
      $display("FAIL full_valid got %b exp 1", m_valid); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (rd_en !== 1'b0) begin errors++;
      $display("FAIL frst_rden got %b exp 0", rd_en); end
    tick();
    #1;
    checks += 4;
    if (m_valid !== 1'b0) begin errors++;
      $display("FAIL frst_valid got %b exp 0", m_valid); end
    if (m_data !== '0) begin errors++;
      $display("FAIL frst_data got %h exp 0", m_data); end
    if (level !== 10'd512) begin errors++;
      $display("FAIL frst_lvl got %0d exp 512", level); end
    if (rptr_gray !== '0) begin errors++;
      $display("FAIL frst_rgray got %h exp 0", rptr_gray); end
    set_w(10'd100);
    #1;
    checks += 2;
    if (level !== 10'd100) begin errors++;
      $display("FAIL frst_lvl2 got %0d exp 100", level); end
    if (rd_en !== 1'b0) begin errors++;
      $display("FAIL frst_rden2 got %b exp 0", rd_en); end
    tick();
    rst_n = 1'b1;
    #1;
    checks++;
    if (rd_en !== 1'b1) begin errors++;
      $display("FAIL frst_resume got %b exp 1", rd_en); end
    tick();
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_burst();
    test_toggle();
    test_random();
    test_wrap();
    test_full_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
